// File: rtl/fir_mac_ctrl.sv
// FIR MAC control sequencer: accepts one sample at a time, walks tap/coef addresses
// and issues the latency-aligned accumulator command stream.
package fir_filter_pkg;
  localparam logic [1:0] MAC_NOP  = 2'd0;
  localparam logic [1:0] MAC_LOAD = 2'd1;
  localparam logic [1:0] MAC_ACC  = 2'd2;
  localparam logic [1:0] MAC_CLR  = 2'd3;
endpackage

// state | meaning
// IDLE  | ready for a sample
// SHIFT | delay-line shift cycle
// RUN   | one tap per cycle, index 0..TAPS-1
// DRAIN | wait MUL_LAT cycles for the last product to land
// DONE  | accumulator holds the final sum
module fir_mac_ctrl
  import fir_filter_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int MUL_LAT  = 1,
  parameter int ADDRBITS = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_in,
  output logic                in_ready_out,
  input  logic                clr_in,
  output logic                shift_out,
  output logic [ADDRBITS-1:0] tap_addr_out,
  output logic [ADDRBITS-1:0] coef_addr_out,
  output logic [1:0]          mac_ctrl_out,
  output logic                out_valid_out
);

  typedef enum logic [2:0] {IDLE, SHIFT, RUN, DRAIN, DONE} state_e;

  localparam logic [ADDRBITS-1:0] LAST_IDX   = ADDRBITS'(TAPS - 1);
  localparam logic [2:0]          DRAIN_INIT = 3'((MUL_LAT > 0) ? MUL_LAT - 1 : 0);

  state_e              state, state_nxt;
  logic [ADDRBITS-1:0] idx, idx_nxt;
  logic [2:0]          drain_cnt, drain_nxt;
  logic                clr_q;
  logic [1:0]          tag;
  logic [1:0]          pipe_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      clr_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      drain_cnt <= drain_nxt;
      clr_q     <= clr_in;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = '0;
    drain_nxt = drain_cnt;
    case (state)
      IDLE: begin
        if (in_valid_in) state_nxt = SHIFT;
      end
      SHIFT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          state_nxt = (MUL_LAT > 0) ? DRAIN : DONE;
          drain_nxt = DRAIN_INIT;
        end else begin
          idx_nxt = idx + ADDRBITS'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt == 3'd0) state_nxt = DONE;
        else                   drain_nxt = drain_cnt - 3'd1;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Abort wins over everything, including a same-cycle handshake.
    if (clr_in) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end
  end

  always_comb begin
    in_ready_out  = (state == IDLE);
    shift_out     = (state == SHIFT) && !clr_in;
    out_valid_out = (state == DONE) && !clr_in;
    tap_addr_out  = (state == RUN) ? idx : '0;
    coef_addr_out = (state == RUN) ? idx : '0;
    tag           = MAC_NOP;
    if (state == RUN) tag = (idx == '0) ? MAC_LOAD : MAC_ACC;
  end

  // Tag pipeline matches the multiplier latency so LOAD meets the first product.
  generate
    if (MUL_LAT == 0) begin : g_nolat
      assign pipe_out = tag;
    end else begin : g_lat
      logic [1:0] pipe [MUL_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MUL_LAT; i++) pipe[i] <= MAC_NOP;
        end else if (clr_in) begin
          for (int i = 0; i < MUL_LAT; i++) pipe[i] <= MAC_NOP;
        end else begin
          pipe[0] <= tag;
          for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign pipe_out = pipe[MUL_LAT-1];
    end
  endgenerate

  assign mac_ctrl_out = clr_q ? MAC_CLR : pipe_out;

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Scoreboard bench for fir_mac_ctrl: three instances (8/1, 1/0, 5/4) with expected
// events queued by the stimulus and popped by a negedge monitor.
module tb_fir_mac_ctrl;
  import fir_filter_pkg::*;

  localparam int K_HS  = 0;
  localparam int K_SH  = 1;
  localparam int K_CMD = 2;
  localparam int K_OV  = 3;

  typedef struct {
    int cyc;
    int kind;
    int val;
    int idx;
    int sum;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       iv0, clr0, rdy0, sh0, ov0;
  logic [2:0] tap0, coef0;
  logic [1:0] mac0;
  logic       iv1, clr1, rdy1, sh1, ov1;
  logic [0:0] tap1, coef1;
  logic [1:0] mac1;
  logic       iv2, clr2, rdy2, sh2, ov2;
  logic [2:0] tap2, coef2;
  logic [1:0] mac2;

  fir_mac_ctrl #(.TAPS(8), .MUL_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid_in(iv0), .in_ready_out(rdy0), .clr_in(clr0),
    .shift_out(sh0), .tap_addr_out(tap0), .coef_addr_out(coef0), .mac_ctrl_out(mac0),
    .out_valid_out(ov0));
  fir_mac_ctrl #(.TAPS(1), .MUL_LAT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid_in(iv1), .in_ready_out(rdy1), .clr_in(clr1),
    .shift_out(sh1), .tap_addr_out(tap1), .coef_addr_out(coef1), .mac_ctrl_out(mac1),
    .out_valid_out(ov1));
  fir_mac_ctrl #(.TAPS(5), .MUL_LAT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid_in(iv2), .in_ready_out(rdy2), .clr_in(clr2),
    .shift_out(sh2), .tap_addr_out(tap2), .coef_addr_out(coef2), .mac_ctrl_out(mac2),
    .out_valid_out(ov2));

  ev_t q [3][$];
  int  checks = 0;
  int  errors = 0;
  int  lat  [3] = '{1, 0, 4};
  int  taps [3] = '{8, 1, 5};

  // datapath model for dut0: delay line, coef ROM 1..8, one-stage multiplier, accumulator
  int dl [8];
  int cur_sample = 0;
  int prod = 0;
  int acc = 0;

  int o_hs [3], o_sh [3], o_mac [3], o_ov [3], o_tap [3], o_coef [3];
  int htap [3][8];
  int hcoef [3][8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int d, input int c, input int k, input int v, input int ix, input int s);
    ev_t e;
    int  pos;
    e.cyc = c; e.kind = k; e.val = v; e.idx = ix; e.sum = s;
    pos = q[d].size();
    while (pos > 0 && (q[d][pos-1].cyc > c || (q[d][pos-1].cyc == c && q[d][pos-1].kind > k)))
      pos--;
    q[d].insert(pos, e);
  endtask

  task automatic push_sample(input int d, input int h, input int s);
    push_ev(d, h, K_HS, 0, -1, -1);
    push_ev(d, h + 1, K_SH, 0, -1, -1);
    for (int k = 0; k < taps[d]; k++)
      push_ev(d, h + 2 + lat[d] + k, K_CMD, (k == 0) ? int'(MAC_LOAD) : int'(MAC_ACC), k, -1);
    push_ev(d, h + taps[d] + 2 + lat[d], K_OV, 0, -1, s);
  endtask

  task automatic observe(input int d, input int k, input int v);
    ev_t e;
    int  hc;
    checks++;
    if (q[d].size() == 0 || q[d][0].cyc != cyc || q[d][0].kind != k) begin
      errors++;
      $display("FAIL unexpected_event dut%0d cyc=%0d got kind=%0d val=%0d exp kind=%0d at cyc=%0d",
               d, cyc, k, v, (q[d].size() > 0) ? q[d][0].kind : -1,
               (q[d].size() > 0) ? q[d][0].cyc : -1);
      return;
    end
    e = q[d].pop_front();
    if (e.val != v) begin
      errors++;
      $display("FAIL event_value dut%0d kind=%0d cyc=%0d got=%0d exp=%0d", d, k, cyc, v, e.val);
    end
    if (k == K_CMD && e.idx >= 0) begin
      hc = (cyc - lat[d]) % 8;
      chk($sformatf("tap_addr_dut%0d", d), htap[d][hc], e.idx);
      chk($sformatf("coef_addr_dut%0d", d), hcoef[d][hc], e.idx);
    end
    if (k == K_OV && e.sum >= 0) chk("fir_sum", acc, e.sum);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      acc = 0;
      prod = 0;
      for (int i = 0; i < 8; i++) dl[i] = 0;
    end else begin
      case (mac0)
        MAC_LOAD: acc = prod;
        MAC_ACC:  acc = acc + prod;
        MAC_CLR:  acc = 0;
        default:  ;
      endcase
      prod = dl[tap0] * (int'(coef0) + 1);
      if (sh0) begin
        for (int i = 7; i > 0; i--) dl[i] = dl[i-1];
        dl[0] = cur_sample;
      end
    end

    o_hs[0] = int'(iv0 && rdy0 && !clr0); o_sh[0] = int'(sh0); o_mac[0] = int'(mac0);
    o_ov[0] = int'(ov0); o_tap[0] = int'(tap0); o_coef[0] = int'(coef0);
    o_hs[1] = int'(iv1 && rdy1 && !clr1); o_sh[1] = int'(sh1); o_mac[1] = int'(mac1);
    o_ov[1] = int'(ov1); o_tap[1] = int'(tap1); o_coef[1] = int'(coef1);
    o_hs[2] = int'(iv2 && rdy2 && !clr2); o_sh[2] = int'(sh2); o_mac[2] = int'(mac2);
    o_ov[2] = int'(ov2); o_tap[2] = int'(tap2); o_coef[2] = int'(coef2);

    for (int d = 0; d < 3; d++) begin
      htap[d][cyc % 8]  = o_tap[d];
      hcoef[d][cyc % 8] = o_coef[d];
      if (o_hs[d] != 0) observe(d, K_HS, 0);
      if (o_sh[d] != 0) observe(d, K_SH, 0);
      if (o_mac[d] != int'(MAC_NOP)) observe(d, K_CMD, o_mac[d]);
      if (o_ov[d] != 0) observe(d, K_OV, 0);
      while (q[d].size() > 0 && q[d][0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event dut%0d cyc=%0d got=none exp kind=%0d val=%0d",
                 d, cyc, q[d][0].kind, q[d][0].val);
        void'(q[d].pop_front());
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  int xs   [3] = '{2, 3, 4};
  int sums [3] = '{2, 7, 16};

  initial begin
    rst_n = 1'b0;
    iv0 = 0; clr0 = 0; iv1 = 0; clr1 = 0; iv2 = 0; clr2 = 0;
    #1;
    chk("rst_ready",  int'(rdy0), 1);
    chk("rst_shift",  int'(sh0), 0);
    chk("rst_tap",    int'(tap0), 0);
    chk("rst_coef",   int'(coef0), 0);
    chk("rst_mac",    int'(mac0), int'(MAC_NOP));
    chk("rst_valid",  int'(ov0), 0);
    chk("rst_ready1", int'(rdy1), 1);
    chk("rst_ready2", int'(rdy2), 1);
    wait_cyc(3);
    rst_n = 1'b1;

    // reset while RUN sits at index 4
    wait_cyc(5);
    iv0 = 1; cur_sample = 9;
    push_ev(0, 5, K_HS, 0, -1, -1);
    push_ev(0, 6, K_SH, 0, -1, -1);
    push_ev(0, 8, K_CMD, int'(MAC_LOAD), 0, -1);
    push_ev(0, 9, K_CMD, int'(MAC_ACC), 1, -1);
    push_ev(0, 10, K_CMD, int'(MAC_ACC), 2, -1);
    wait_cyc(6);
    iv0 = 0;
    wait_cyc(11);
    chk("pre_rst_tap", int'(tap0), 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", int'(rdy0), 1);
    chk("midrst_tap",   int'(tap0), 0);
    chk("midrst_coef",  int'(coef0), 0);
    chk("midrst_mac",   int'(mac0), int'(MAC_NOP));
    chk("midrst_shift", int'(sh0), 0);
    chk("midrst_valid", int'(ov0), 0);
    wait_cyc(13);
    rst_n = 1'b1;

    // three samples back to back with in_valid held high
    for (int i = 0; i < 3; i++) begin
      wait_cyc(20 + 12 * i);
      iv0 = 1;
      cur_sample = xs[i];
      push_sample(0, 20 + 12 * i, sums[i]);
      if (i == 0) begin
        wait_cyc(31);
        chk("busy_ready_c11", int'(rdy0), 0);
        chk("valid_c11", int'(ov0), 1);
      end
    end
    wait_cyc(45);
    iv0 = 0;

    // abort at cycle 6 of a sample
    wait_cyc(60);
    iv0 = 1; cur_sample = 5;
    push_ev(0, 60, K_HS, 0, -1, -1);
    push_ev(0, 61, K_SH, 0, -1, -1);
    push_ev(0, 63, K_CMD, int'(MAC_LOAD), 0, -1);
    push_ev(0, 64, K_CMD, int'(MAC_ACC), 1, -1);
    push_ev(0, 65, K_CMD, int'(MAC_ACC), 2, -1);
    push_ev(0, 66, K_CMD, int'(MAC_ACC), 3, -1);
    push_ev(0, 67, K_CMD, int'(MAC_CLR), -1, -1);
    wait_cyc(61);
    iv0 = 0;
    wait_cyc(66);
    clr0 = 1;
    wait_cyc(67);
    clr0 = 0;
    chk("clr_ready", int'(rdy0), 1);
    chk("clr_tap", int'(tap0), 0);

    // clr and handshake together in IDLE
    wait_cyc(75);
    iv0 = 1; clr0 = 1; cur_sample = 6;
    push_ev(0, 76, K_CMD, int'(MAC_CLR), -1, -1);
    push_sample(0, 76, -1);
    wait_cyc(76);
    clr0 = 0;
    chk("clr_hs_noshift", int'(sh0), 0);
    wait_cyc(77);
    iv0 = 0;

    // clr held for two cycles
    wait_cyc(95);
    clr0 = 1;
    push_ev(0, 96, K_CMD, int'(MAC_CLR), -1, -1);
    push_ev(0, 97, K_CMD, int'(MAC_CLR), -1, -1);
    wait_cyc(97);
    clr0 = 0;
    chk("clr_held_ready", int'(rdy0), 1);

    // parameter corners
    wait_cyc(100);
    iv1 = 1; iv2 = 1;
    push_sample(1, 100, -1);
    push_sample(2, 100, -1);
    push_sample(1, 104, -1);
    wait_cyc(101);
    iv2 = 0;
    wait_cyc(103);
    chk("t1_valid_c3", int'(ov1), 1);
    wait_cyc(105);
    iv1 = 0;
    wait_cyc(111);
    chk("t5_valid_c11", int'(ov2), 1);

    wait_cyc(125);
    for (int d = 0; d < 3; d++) chk($sformatf("queue_empty_dut%0d", d), q[d].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
